program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset named as below.
REQ-002 The ports SHALL be exactly:
- clk  input  1  rising-edge clock
- sync_reset  input  1  asynchronous, active-high reset
- jmp  input  1  unconditional jump decoded in ir
- jmp_nz  input  1  conditional jump decoded in ir
- dont_jmp  input  1  ALU zero flag; suppresses jmp_nz
- jmp_addr  input  4  ir_nibble; jump target = {jmp_addr, 4'h0}
- boot_halt  input  1  sampled at reset release; 1 = start in HALTED
- run  input  1  level; leave HALTED
- halt  input  1  level; enter HALTED
- step  input  1  pulse; execute exactly one instruction from HALTED
- bp_en  input  1  breakpoint enable
- bp_addr  input  8  breakpoint address
- pm_addr  output  8  program-memory fetch address (combinational)
- pc  output  8  address of the instruction now in ir
- hold  output  1  1 = datapath register enables and jumps are suppressed this cycle
- state  output  2  00 RESET_S, 01 RUN, 10 HALTED, 11 STEP
- retired  output  16  count of executed instructions

Function
REQ-003 The pc register SHALL load pm_addr on every rising clk edge, so that ir and pc always refer to the same instruction.
REQ-004 With hold=1, pm_addr SHALL equal pc, so that ir re-fetches and keeps the same instruction.
REQ-005 With hold=0, pm_addr SHALL be selected in this priority:
- {jmp_addr,4'h0} if jmp=1
- {jmp_addr,4'h0} if jmp_nz=1 and dont_jmp=0
- pc+1 otherwise, modulo 256 (8'hFF wraps to 8'h00)
REQ-006 hold SHALL be 1 in RESET_S and HALTED, and 0 in RUN and STEP.
REQ-007 Jump inputs SHALL be ignored whenever hold=1.
REQ-008 In RESET_S, pm_addr SHALL be 8'h00.
REQ-009 The first edge after reset release SHALL leave RESET_S for HALTED if boot_halt=1, and for RUN otherwise.
REQ-010 RUN SHALL go to HALTED on any edge where halt=1; the instruction in ir during that cycle still executes.
REQ-011 RUN SHALL go to HALTED when bp_en=1, pm_addr==bp_addr and the cycle is not the first RUN cycle after leaving HALTED. The fetch completes (pc becomes bp_addr), but that instruction is not executed until run or step.
REQ-012 HALTED SHALL transition as follows, in priority order:
- halt=1: stay in HALTED
- step=1: go to STEP
- run=1: go to RUN
- otherwise: stay in HALTED
REQ-013 STEP SHALL last exactly one cycle, executing the instruction in ir and fetching per REQ-005, and SHALL then return to HALTED unconditionally; breakpoints are not evaluated in STEP.
REQ-014 retired SHALL increment by 1 on each edge where hold=0, saturate at 16'hFFFF, and never wrap.
REQ-015 state SHALL be a registered output; pm_addr and hold SHALL be purely combinational from state, pc and the inputs, with no internal latches.

Reset
REQ-016 While sync_reset=1, the module SHALL hold pc=8'h00, state=RESET_S, retired=16'h0000, pm_addr=8'h00 and hold=1, asynchronously and regardless of clk.
REQ-017 Reset asserted mid-RUN, mid-STEP or in HALTED SHALL abort immediately: no partial step and no retired increment on the asserting edge.
REQ-018 The first-RUN-cycle breakpoint mask SHALL clear on reset.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset release, boot_halt=0, no jumps, 5 cycles -> state RESET_S then RUN; pc 00,01,02,03,04; retired=4.
- pc=8'hFF in RUN, no jump -> pm_addr=8'h00; next pc=8'h00.
- jmp_nz=1, jmp_addr=4'h3, dont_jmp=1 -> pm_addr=pc+1. Same with dont_jmp=0 -> pm_addr=8'h30. jmp=1 with jmp_nz=1 -> 8'h30.
- bp_en=1, bp_addr=8'h05, running from 00 -> pc reaches 05, state=HALTED, hold=1, retired=5 and frozen. run=1 -> RUN, no re-trigger at 05, pc advances to 06.
- HALTED at pc=8'h10, one-cycle step pulse -> one STEP cycle; pc=8'h11; back to HALTED; retired +1. step and run high together -> STEP wins.
- sync_reset pulsed between clock edges during RUN at pc=8'h22 -> pc=8'h00, state=RESET_S and retired=0 immediately, before the next edge.

Source files
------------

// File: rtl/program_sequencer.sv
// Program sequencer: fetch-address generation, jump selection and a
// run/halt/step/breakpoint debug controller for a simple in-order core.
module program_sequencer (
  input  logic        clk,
  input  logic        sync_reset,
  input  logic        jmp,
  input  logic        jmp_nz,
  input  logic        dont_jmp,
  input  logic [3:0]  jmp_addr,
  input  logic        boot_halt,
  input  logic        run,
  input  logic        halt,
  input  logic        step,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  output logic [7:0]  pm_addr,
  output logic [7:0]  pc,
  output logic        hold,
  output logic [1:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    RESET_S = 2'b00,
    RUN     = 2'b01,
    HALTED  = 2'b10,
    STEP    = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q;
  logic [15:0] retired_q;
  logic        first_run_q;
  logic        bp_hit;
  logic [7:0]  jump_target;

  assign jump_target = {jmp_addr, 4'h0};

  // Fetch address: re-fetch the current instruction while held so ir and pc stay paired.
  always_comb begin
    hold    = (state_q == RESET_S) || (state_q == HALTED);
    pm_addr = pc_q + 8'd1;
    if (state_q == RESET_S) begin
      pm_addr = 8'h00;
    end else if (hold) begin
      pm_addr = pc_q;
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      pm_addr = jump_target;
    end
  end

  // The first RUN cycle after a resume is masked so we can leave a breakpoint address.
  assign bp_hit = bp_en && !first_run_q && (pm_addr == bp_addr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_S: state_d = boot_halt ? HALTED : RUN;
      RUN: begin
        if (halt || bp_hit) state_d = HALTED;
      end
      HALTED: begin
        if (halt)      state_d = HALTED;
        else if (step) state_d = STEP;
        else if (run)  state_d = RUN;
      end
      STEP:    state_d = HALTED;
      default: state_d = RESET_S;
    endcase
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state_q     <= RESET_S;
      pc_q        <= 8'h00;
      retired_q   <= 16'h0000;
      first_run_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pm_addr;
      first_run_q <= (state_q == HALTED) && (state_d == RUN);
      if (!hold && (retired_q != 16'hFFFF)) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  assign pc      = pc_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: the driver pushes hand-computed
// expected output vectors, a monitor pops and compares them at sample points.
module tb_program_sequencer;

  logic        clk;
  logic        sync_reset;
  logic        jmp, jmp_nz, dont_jmp;
  logic [3:0]  jmp_addr;
  logic        boot_halt, run, halt, step, bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  pm_addr, pc;
  logic        hold;
  logic [1:0]  state;
  logic [15:0] retired;

  localparam int W = 35;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           failures = 0;
  logic         mid_strobe = 1'b0;

  program_sequencer dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .dont_jmp   (dont_jmp),
    .jmp_addr   (jmp_addr),
    .boot_halt  (boot_halt),
    .run        (run),
    .halt       (halt),
    .step       (step),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pm_addr    (pm_addr),
    .pc         (pc),
    .hold       (hold),
    .state      (state),
    .retired    (retired)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input logic [7:0] e_pm, input logic [7:0] e_pc,
                          input logic e_hold, input logic [1:0] e_st, input logic [15:0] e_ret);
    exp_q.push_back({e_pm, e_pc, e_hold, e_st, e_ret});
    name_q.push_back(nm);
  endtask

  // Scoreboard monitor: samples on the falling edge or on an explicit mid-cycle strobe
  initial begin
    logic [W-1:0] e, a;
    string        nm;
    forever begin
      @(negedge clk or posedge mid_strobe);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {pm_addr, pc, hold, state, retired};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got pm_addr=%h pc=%h hold=%b state=%b retired=%h, expected pm_addr=%h pc=%h hold=%b state=%b retired=%h",
                   nm, a[34:27], a[26:19], a[18], a[17:16], a[15:0],
                   e[34:27], e[26:19], e[18], e[17:16], e[15:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    sync_reset = 1'b1;
    jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0; jmp_addr = 4'h0;
    boot_halt = 1'b0; run = 1'b0; halt = 1'b0; step = 1'b0;
    bp_en = 1'b0; bp_addr = 8'h00;

    // Reset release into RUN, sequential fetch
    cyc(); expect_v("reset_held",    8'h00, 8'h00, 1'b1, 2'b00, 16'd0);
    cyc(); sync_reset = 1'b0;
           expect_v("reset_release", 8'h00, 8'h00, 1'b1, 2'b00, 16'd0);
    cyc(); expect_v("run_c1", 8'h01, 8'h00, 1'b0, 2'b01, 16'd0);
    cyc(); expect_v("run_c2", 8'h02, 8'h01, 1'b0, 2'b01, 16'd1);
    cyc(); expect_v("run_c3", 8'h03, 8'h02, 1'b0, 2'b01, 16'd2);
    cyc(); expect_v("run_c4", 8'h04, 8'h03, 1'b0, 2'b01, 16'd3);
    cyc(); expect_v("run_c5", 8'h05, 8'h04, 1'b0, 2'b01, 16'd4);

    // Jump selection
    cyc(); jmp_nz = 1'b1; jmp_addr = 4'h3; dont_jmp = 1'b1;
           expect_v("jnz_suppressed", 8'h06, 8'h05, 1'b0, 2'b01, 16'd5);
    cyc(); dont_jmp = 1'b0;
           expect_v("jnz_taken",      8'h30, 8'h06, 1'b0, 2'b01, 16'd6);
    cyc(); jmp = 1'b1; dont_jmp = 1'b1;
           expect_v("jmp_priority",   8'h30, 8'h30, 1'b0, 2'b01, 16'd7);
    cyc(); jmp_nz = 1'b0; dont_jmp = 1'b0; jmp_addr = 4'hF;
           expect_v("jmp_f0",         8'hF0, 8'h30, 1'b0, 2'b01, 16'd8);
    cyc(); jmp = 1'b0;
           expect_v("run_f0",         8'hF1, 8'hF0, 1'b0, 2'b01, 16'd9);

    // Walk up to FF and wrap to 00
    for (int i = 1; i <= 15; i++) begin
      cyc();
      expect_v((i == 15) ? "pc_wrap" : "walk_to_ff",
               8'(8'hF1 + i), 8'(8'hF0 + i), 1'b0, 2'b01, 16'(9 + i));
    end
    cyc(); jmp = 1'b1; jmp_addr = 4'h2;
           expect_v("after_wrap", 8'h20, 8'h00, 1'b0, 2'b01, 16'd25);
    cyc(); jmp = 1'b0;
           expect_v("run_20", 8'h21, 8'h20, 1'b0, 2'b01, 16'd26);
    cyc(); expect_v("run_21", 8'h22, 8'h21, 1'b0, 2'b01, 16'd27);
    cyc(); expect_v("run_22", 8'h23, 8'h22, 1'b0, 2'b01, 16'd28);

    // Asynchronous reset between edges
    @(negedge clk); #1;
    sync_reset = 1'b1;
    #1;
    expect_v("async_reset", 8'h00, 8'h00, 1'b1, 2'b00, 16'd0);
    mid_strobe = 1'b1;
    #1 mid_strobe = 1'b0;

    // Breakpoint at 05 from a fresh start
    cyc(); bp_en = 1'b1; bp_addr = 8'h05;
           expect_v("reset_hold", 8'h00, 8'h00, 1'b1, 2'b00, 16'd0);
    cyc(); sync_reset = 1'b0;
           expect_v("bp_release", 8'h00, 8'h00, 1'b1, 2'b00, 16'd0);
    cyc(); expect_v("bp_c1", 8'h01, 8'h00, 1'b0, 2'b01, 16'd0);
    cyc(); expect_v("bp_c2", 8'h02, 8'h01, 1'b0, 2'b01, 16'd1);
    cyc(); expect_v("bp_c3", 8'h03, 8'h02, 1'b0, 2'b01, 16'd2);
    cyc(); expect_v("bp_c4", 8'h04, 8'h03, 1'b0, 2'b01, 16'd3);
    cyc(); expect_v("bp_c5", 8'h05, 8'h04, 1'b0, 2'b01, 16'd4);
    cyc(); expect_v("bp_hit",    8'h05, 8'h05, 1'b1, 2'b10, 16'd5);
    cyc(); expect_v("bp_frozen", 8'h05, 8'h05, 1'b1, 2'b10, 16'd5);
    cyc(); run = 1'b1;
           expect_v("bp_run_req", 8'h05, 8'h05, 1'b1, 2'b10, 16'd5);
    cyc(); run = 1'b0;
           expect_v("bp_resume",  8'h06, 8'h05, 1'b0, 2'b01, 16'd5);

    // Self-jump at a breakpoint: first RUN cycle masked, second re-triggers
    cyc(); jmp = 1'b1; jmp_addr = 4'h1; bp_addr = 8'h10;
           expect_v("bp_jmp10",       8'h10, 8'h06, 1'b0, 2'b01, 16'd6);
    cyc(); run = 1'b1;
           expect_v("bp_at_10",       8'h10, 8'h10, 1'b1, 2'b10, 16'd7);
    cyc(); run = 1'b0;
           expect_v("mask_first_run", 8'h10, 8'h10, 1'b0, 2'b01, 16'd7);
    cyc(); expect_v("mask_expired",   8'h10, 8'h10, 1'b0, 2'b01, 16'd8);
    cyc(); jmp = 1'b0; bp_en = 1'b0;
           expect_v("halted_10",      8'h10, 8'h10, 1'b1, 2'b10, 16'd9);

    // Single step, then step beating run
    cyc(); step = 1'b1;
           expect_v("step_req",     8'h10, 8'h10, 1'b1, 2'b10, 16'd9);
    cyc(); step = 1'b0;
           expect_v("step_exec",    8'h11, 8'h10, 1'b0, 2'b11, 16'd9);
    cyc(); expect_v("step_done",    8'h11, 8'h11, 1'b1, 2'b10, 16'd10);
    cyc(); step = 1'b1; run = 1'b1;
           expect_v("step_run_req", 8'h11, 8'h11, 1'b1, 2'b10, 16'd10);
    cyc(); step = 1'b0; run = 1'b0;
           expect_v("step_wins",    8'h12, 8'h11, 1'b0, 2'b11, 16'd10);
    cyc(); run = 1'b1;
           expect_v("step2_done",   8'h12, 8'h12, 1'b1, 2'b10, 16'd11);

    // Halt from RUN executes the current instruction; halt beats run
    cyc(); run = 1'b0; halt = 1'b1;
           expect_v("halt_req",      8'h13, 8'h12, 1'b0, 2'b01, 16'd11);
    cyc(); run = 1'b1; jmp = 1'b1; jmp_addr = 4'h7;
           expect_v("halted_13",     8'h13, 8'h13, 1'b1, 2'b10, 16'd12);
    cyc(); halt = 1'b0; run = 1'b0; jmp = 1'b0;
           expect_v("halt_priority", 8'h13, 8'h13, 1'b1, 2'b10, 16'd12);

    // Boot into HALTED
    cyc(); sync_reset = 1'b1; boot_halt = 1'b1;
           expect_v("reset_again",  8'h00, 8'h00, 1'b1, 2'b00, 16'd0);
    cyc(); sync_reset = 1'b0;
           expect_v("boot_release", 8'h00, 8'h00, 1'b1, 2'b00, 16'd0);
    cyc(); expect_v("boot_halted",  8'h00, 8'h00, 1'b1, 2'b10, 16'd0);
    cyc(); boot_halt = 1'b0;
           expect_v("boot_stays",   8'h00, 8'h00, 1'b1, 2'b10, 16'd0);

    // Final report
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
